// File: rtl/hazard_ctrl_ml_if.sv
// Hazard-controller bundle: ID/EX hazard inputs in, pipeline steering outputs out.
// Zero-latency combinational path through the controller; no backpressure on this bundle.
interface hazard_ctrl_ml_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic              id_ex_mem_read_i;
  logic [REG_AW-1:0] id_ex_rt_i;
  logic [REG_AW-1:0] if_id_rs_i;
  logic [REG_AW-1:0] if_id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic              ex_md_start_i;
  logic              id_uses_hilo_i;
  logic              ex_branch_taken_i;

  logic              pc_write_o;
  logic              if_id_write_o;
  logic              if_id_flush_o;
  logic              id_ex_nop_o;
  logic              busy_md_o;
  logic [PERF_W-1:0] stall_cycles_o;

  // Pipeline side drives hazard information and consumes steering signals.
  modport master (
    output id_ex_mem_read_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
    output id_use_rs_i, id_use_rt_i, ex_md_start_i, id_uses_hilo_i,
    output ex_branch_taken_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_nop_o,
    input  busy_md_o, stall_cycles_o
  );

  modport slave (
    input  id_ex_mem_read_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
    input  id_use_rs_i, id_use_rt_i, ex_md_start_i, id_uses_hilo_i,
    input  ex_branch_taken_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_nop_o,
    output busy_md_o, stall_cycles_o
  );
endinterface

// File: rtl/hazard_ctrl_ml.sv
// 5-stage MIPS hazard controller: multi-cycle load-use stall, HI/LO interlock, branch flush.
// Outputs are combinational from state + inputs (0 cycles); stall holds PC/IF-ID, flush overrides.
module hazard_ctrl_ml #(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALL  = 1,
  parameter int MD_LAT      = 4,
  parameter int ZERO_EXEMPT = 1,
  parameter int PERF_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_ml_if.slave  hz
);

  localparam int LCW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam int MCW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  localparam logic [LCW-1:0] LOAD_RELOAD = LCW'(LOAD_STALL - 1);
  localparam logic [MCW-1:0] MD_RELOAD   = MCW'(MD_LAT - 1);

  logic [LCW-1:0]    load_cnt_q, load_cnt_d;
  logic [MCW-1:0]    md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [REG_AW-1:0] ex_rt, id_rs, id_rt;
  logic              hit_rs, hit_rt, lu;
  logic              ld_stall, md_stall, busy_md, stall, flush;

  assign ex_rt = hz.id_ex_rt_i;
  assign id_rs = hz.if_id_rs_i;
  assign id_rt = hz.if_id_rt_i;

  // Register 0 is hard-wired, so a load "to" it never produces a real dependence.
  assign hit_rs = hz.id_use_rs_i && (id_rs == ex_rt) &&
                  !((ZERO_EXEMPT != 0) && (id_rs == '0));
  assign hit_rt = hz.id_use_rt_i && (id_rt == ex_rt) &&
                  !((ZERO_EXEMPT != 0) && (id_rt == '0));
  assign lu     = hz.id_ex_mem_read_i && (hit_rs || hit_rt);

  assign ld_stall = lu || (load_cnt_q != '0);
  assign busy_md  = (md_cnt_q != '0);
  assign md_stall = hz.id_uses_hilo_i && busy_md;
  assign stall    = ld_stall || md_stall;
  assign flush    = hz.ex_branch_taken_i;

  always_comb begin
    load_cnt_d = load_cnt_q;
    if (flush) begin
      load_cnt_d = '0;
    end else if (load_cnt_q != '0) begin
      load_cnt_d = load_cnt_q - LCW'(1);
    end else if (lu) begin
      load_cnt_d = LOAD_RELOAD;
    end
  end

  // The mult/div unit runs to completion regardless of stalls or flushes.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.ex_md_start_i) begin
      md_cnt_d = MD_RELOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MCW'(1);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !flush && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q     <= '0;
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      load_cnt_q     <= load_cnt_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // A taken branch squashes the stalled instruction, so the stall is moot that cycle.
  always_comb begin
    hz.pc_write_o    = 1'b1;
    hz.if_id_write_o = 1'b1;
    hz.if_id_flush_o = 1'b0;
    hz.id_ex_nop_o   = 1'b0;
    if (flush) begin
      hz.if_id_flush_o = 1'b1;
      hz.id_ex_nop_o   = 1'b1;
    end else if (stall) begin
      hz.pc_write_o    = 1'b0;
      hz.if_id_write_o = 1'b0;
      hz.id_ex_nop_o   = 1'b1;
    end
  end

  assign hz.busy_md_o      = busy_md;
  assign hz.stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl_ml.sv
// Directed bench for hazard_ctrl_ml: one instance with single-bubble loads/16-bit counter,
// one with three-bubble loads and a 4-bit counter to reach saturation.
module tb_hazard_ctrl_ml;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctrl_ml_if #(.REG_AW(5), .PERF_W(16)) if1 ();
  hazard_ctrl_ml_if #(.REG_AW(5), .PERF_W(4))  if3 ();

  hazard_ctrl_ml #(.REG_AW(5), .LOAD_STALL(1), .MD_LAT(4), .ZERO_EXEMPT(1), .PERF_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if1)
  );

  hazard_ctrl_ml #(.REG_AW(5), .LOAD_STALL(3), .MD_LAT(4), .ZERO_EXEMPT(1), .PERF_W(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {if1.id_ex_mem_read_i, if1.id_use_rs_i, if1.id_use_rt_i, if1.ex_md_start_i,
     if1.id_uses_hilo_i, if1.ex_branch_taken_i} = '0;
    {if3.id_ex_mem_read_i, if3.id_use_rs_i, if3.id_use_rt_i, if3.ex_md_start_i,
     if3.id_uses_hilo_i, if3.ex_branch_taken_i} = '0;
    if1.id_ex_rt_i = '0; if1.if_id_rs_i = '0; if1.if_id_rt_i = '0;
    if3.id_ex_rt_i = '0; if3.if_id_rs_i = '0; if3.if_id_rt_i = '0;

    #12;
    chk("rst_pc_write",    32'(if1.pc_write_o),     32'd1);
    chk("rst_if_id_write", 32'(if1.if_id_write_o),  32'd1);
    chk("rst_flush",       32'(if1.if_id_flush_o),  32'd0);
    chk("rst_nop",         32'(if1.id_ex_nop_o),    32'd0);
    chk("rst_busy",        32'(if1.busy_md_o),      32'd0);
    chk("rst_stall_cnt",   32'(if1.stall_cycles_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single-bubble load-use on rs.
    tick();
    if1.id_ex_mem_read_i = 1'b1; if1.id_ex_rt_i = 5'd5;
    if1.if_id_rs_i = 5'd5; if1.id_use_rs_i = 1'b1;
    #2;
    chk("lu1_pc_write",    32'(if1.pc_write_o),    32'd0);
    chk("lu1_if_id_write", 32'(if1.if_id_write_o), 32'd0);
    chk("lu1_nop",         32'(if1.id_ex_nop_o),   32'd1);
    chk("lu1_flush",       32'(if1.if_id_flush_o), 32'd0);
    tick();
    if1.id_ex_mem_read_i = 1'b0;
    #2;
    chk("lu1_release_pc",  32'(if1.pc_write_o),     32'd1);
    chk("lu1_release_nop", 32'(if1.id_ex_nop_o),    32'd0);
    chk("lu1_stall_cnt",   32'(if1.stall_cycles_o), 32'd1);

    // $zero exemption and use-enables (combinational only, cleared before the edge).
    if1.id_use_rs_i = 1'b0; if1.if_id_rs_i = 5'd7;
    if1.id_ex_mem_read_i = 1'b1; if1.id_ex_rt_i = 5'd0;
    if1.if_id_rt_i = 5'd0; if1.id_use_rt_i = 1'b1;
    #1;
    chk("zero_exempt_pc",  32'(if1.pc_write_o),  32'd1);
    chk("zero_exempt_nop", 32'(if1.id_ex_nop_o), 32'd0);
    if1.id_use_rt_i = 1'b0;
    #1;
    chk("no_use_pc",       32'(if1.pc_write_o),  32'd1);
    if1.id_ex_rt_i = 5'd9; if1.if_id_rt_i = 5'd9;
    #1;
    chk("rt_unused_pc",    32'(if1.pc_write_o),  32'd1);
    if1.id_use_rt_i = 1'b1;
    #1;
    chk("rt_hit_pc",       32'(if1.pc_write_o),  32'd0);
    if1.id_ex_mem_read_i = 1'b0; if1.id_use_rt_i = 1'b0;

    // Mult/div interlock: start at c0, HI/LO user from c1.
    tick();
    if1.ex_md_start_i = 1'b1;
    #2;
    chk("md_c0_busy", 32'(if1.busy_md_o),  32'd0);
    chk("md_c0_pc",   32'(if1.pc_write_o), 32'd1);
    tick();
    if1.ex_md_start_i = 1'b0; if1.id_uses_hilo_i = 1'b1;
    #2;
    chk("md_c1_busy", 32'(if1.busy_md_o),   32'd1);
    chk("md_c1_pc",   32'(if1.pc_write_o),  32'd0);
    chk("md_c1_nop",  32'(if1.id_ex_nop_o), 32'd1);
    tick(); #2;
    chk("md_c2_pc",   32'(if1.pc_write_o),  32'd0);
    tick(); #2;
    chk("md_c3_busy", 32'(if1.busy_md_o),   32'd1);
    chk("md_c3_pc",   32'(if1.pc_write_o),  32'd0);
    tick(); #2;
    chk("md_c4_busy", 32'(if1.busy_md_o),      32'd0);
    chk("md_c4_pc",   32'(if1.pc_write_o),     32'd1);
    chk("md_c4_cnt",  32'(if1.stall_cycles_o), 32'd4);
    if1.id_uses_hilo_i = 1'b0;

    // Three-bubble load-use from a single pulse.
    tick();
    if3.id_ex_mem_read_i = 1'b1; if3.id_ex_rt_i = 5'd12;
    if3.if_id_rt_i = 5'd12; if3.id_use_rt_i = 1'b1;
    #2;
    chk("ls3_c0_pc", 32'(if3.pc_write_o), 32'd0);
    tick();
    if3.id_ex_mem_read_i = 1'b0;
    #2;
    chk("ls3_c1_pc", 32'(if3.pc_write_o), 32'd0);
    tick(); #2;
    chk("ls3_c2_nop", 32'(if3.id_ex_nop_o), 32'd1);
    tick(); #2;
    chk("ls3_c3_pc",  32'(if3.pc_write_o),     32'd1);
    chk("ls3_c3_nop", 32'(if3.id_ex_nop_o),    32'd0);
    chk("ls3_cnt",    32'(if3.stall_cycles_o), 32'd3);

    // Branch taken in the second stall cycle overrides the stall and cancels the rest.
    if3.id_ex_mem_read_i = 1'b1;
    #1;
    chk("br_c0_pc", 32'(if3.pc_write_o), 32'd0);
    tick();
    if3.id_ex_mem_read_i = 1'b0; if3.ex_branch_taken_i = 1'b1;
    #2;
    chk("br_c1_flush", 32'(if3.if_id_flush_o), 32'd1);
    chk("br_c1_pc",    32'(if3.pc_write_o),    32'd1);
    chk("br_c1_ifid",  32'(if3.if_id_write_o), 32'd1);
    chk("br_c1_nop",   32'(if3.id_ex_nop_o),   32'd1);
    tick();
    if3.ex_branch_taken_i = 1'b0;
    #2;
    chk("br_c2_pc",    32'(if3.pc_write_o),     32'd1);
    chk("br_c2_flush", 32'(if3.if_id_flush_o),  32'd0);
    chk("br_cnt",      32'(if3.stall_cycles_o), 32'd4);

    // Long HI/LO interlock saturates the 4-bit counter; then reset asynchronously.
    if3.ex_md_start_i = 1'b1; if3.id_uses_hilo_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #2;
    chk("sat_pc",  32'(if3.pc_write_o),     32'd0);
    chk("sat_cnt", 32'(if3.stall_cycles_o), 32'd15);
    rst_n = 1'b0;
    #1;
    chk("arst_pc",   32'(if3.pc_write_o),     32'd1);
    chk("arst_nop",  32'(if3.id_ex_nop_o),    32'd0);
    chk("arst_busy", 32'(if3.busy_md_o),      32'd0);
    chk("arst_cnt",  32'(if3.stall_cycles_o), 32'd0);
    chk("arst_cnt1", 32'(if1.stall_cycles_o), 32'd0);

    if3.ex_md_start_i = 1'b0; if3.id_uses_hilo_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
